// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and write-request type for the register file writer
package regfile_pkg;

    localparam int DATA_W     = 64;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = $clog2(NUM_REGS);
    localparam int ZERO_REG   = 31;
    localparam int FIFO_DEPTH = 2;

    // One pending register write as held in the buffer
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // The hardwired-zero register swallows writes without storing them
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(ZERO_REG);
    endfunction

endpackage

// File: rtl/decoder5_32.sv
// rtl/decoder5_32.sv - 5-to-32 one-hot decoder with enable
module decoder5_32 (
    input  logic [4:0]  i_addr,
    input  logic        i_en,
    output logic [31:0] o_onehot
);

    // Single bit set at i_addr when enabled, all zero otherwise
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - buffered in-order register file write port with hardwired zero register
module regfile_writer #(
    parameter int      DATA_W     = regfile_pkg::DATA_W,
    parameter int      NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int      FIFO_DEPTH = regfile_pkg::FIFO_DEPTH,
    localparam int     ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic [NUM_REGS-1:0][DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]               wr_en,
    output logic                              busy
);

    import regfile_pkg::*;

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    wr_req_t                          r_fifo [FIFO_DEPTH];
    logic    [PTR_W-1:0]              r_wr_ptr;
    logic    [PTR_W-1:0]              r_rd_ptr;
    logic    [CNT_W-1:0]              r_count;
    logic    [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    logic                             w_push;
    logic                             w_pop;
    logic                             w_commit_en;
    wr_req_t                          w_head;
    logic    [31:0]                   w_dec;

    // Ready depends only on the registered occupancy, so no combinational path from wr_valid
    assign wr_ready    = (r_count != FULL_CNT);
    assign busy        = (r_count != '0);
    assign w_push      = wr_valid && wr_ready;
    // The head drains every cycle the buffer is non-empty; nothing can stall a commit
    assign w_pop       = (r_count != '0);
    assign w_head      = r_fifo[r_rd_ptr];
    // Writes aimed at the zero register are popped but never produce an enable
    assign w_commit_en = w_pop && !is_zero_reg(w_head.addr);

    decoder5_32 u_dec (
        .i_addr   (w_head.addr),
        .i_en     (w_commit_en),
        .o_onehot (w_dec)
    );

    assign wr_en = w_dec;
    assign regs  = r_regs;

    // Buffer storage: payload is only written on an accepted request
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    // Pointers and occupancy; reset discards anything still pending
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register array: commit the head into the register selected by the decoded enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (w_dec[i]) begin
                    r_regs[i] <= w_head.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - table-driven and scoreboard bench for regfile_writer
module tb_regfile_writer;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } req_t;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [31:0] exp_wr_en;
        logic [63:0] exp_reg;
    } vec_t;

    logic              clk;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [4:0]        wr_addr;
    logic [63:0]       wr_data;
    logic [31:0][63:0] regs;
    logic [31:0]       wr_en;
    logic              busy;

    int          n_vec;
    int          n_fail;
    req_t        exp_q[$];
    logic [63:0] model_regs [32];
    int          mon_bad;
    req_t        mon_e;
    vec_t        tbl [6];

    regfile_writer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .regs     (regs),
        .wr_en    (wr_en),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_onehot(input logic [4:0] a);
        logic [31:0] v;
        v = 32'd1 << a;
        if (a == 5'd31) v = '0;
        return v;
    endfunction

    // Drive one request for one edge, record it as accepted, then release the bus with junk
    task automatic send(input logic [4:0] a, input logic [63:0] d);
        req_t r;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
        #1;
        wr_valid = 1'b0;
        wr_addr  = 5'($urandom);
        wr_data  = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            wr_valid = 1'b0;
            wr_addr  = 5'($urandom);
            wr_data  = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 64'hFFFF_0000_FFFF_0000;
        repeat (n) @(posedge clk);
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        #1;
        reset_n  = 1'b1;
        wr_valid = 1'b0;
    endtask

    // Scoreboard monitor: regs against model, busy/ready against queue, pop on each commit
    always @(negedge clk) begin
        if (reset_n) begin
            mon_bad = -1;
            for (int i = 0; i < 32; i++) begin
                if (regs[i] !== model_regs[i]) mon_bad = i;
            end
            n_vec++;
            if (mon_bad >= 0) begin
                n_fail++;
                $display("FAIL mon_regs[%0d]: got 0x%0h, expected 0x%0h",
                         mon_bad, regs[mon_bad], model_regs[mon_bad]);
            end
            chk("mon_ready", 64'(wr_ready), 64'd1);
            chk("mon_busy", 64'(busy), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("mon_wr_en", 64'(wr_en), 64'(exp_onehot(mon_e.addr)));
                if (mon_e.addr != 5'd31) model_regs[mon_e.addr] = mon_e.data;
            end else begin
                chk("mon_wr_en_idle", 64'(wr_en), 64'd0);
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;

        tbl[0] = '{5'd3,  64'hDEAD_BEEF_0000_0001, 32'h0000_0008, 64'hDEAD_BEEF_0000_0001};
        tbl[1] = '{5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 64'h0};
        tbl[2] = '{5'd0,  64'h0123_4567_89AB_CDEF, 32'h0000_0001, 64'h0123_4567_89AB_CDEF};
        tbl[3] = '{5'd30, 64'hA5A5_A5A5_5A5A_5A5A, 32'h4000_0000, 64'hA5A5_A5A5_5A5A_5A5A};
        tbl[4] = '{5'd16, 64'h0000_0000_0000_0042, 32'h0001_0000, 64'h42};
        tbl[5] = '{5'd3,  64'h0,                   32'h0000_0008, 64'h0};

        do_reset(2);
        @(negedge clk);
        chk("rst_ready", 64'(wr_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_regs3", regs[3], 64'd0);

        // Isolated single writes: enable one cycle after acceptance, data visible after commit
        for (int v = 0; v < 6; v++) begin
            send(tbl[v].addr, tbl[v].data);
            @(negedge clk);
            chk("tbl_wr_en", 64'(wr_en), 64'(tbl[v].exp_wr_en));
            chk("tbl_busy_pend", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("tbl_reg", regs[tbl[v].addr], tbl[v].exp_reg);
            chk("tbl_busy_done", 64'(busy), 64'd0);
            chk("tbl_wr_en_done", 64'(wr_en), 64'd0);
        end
        chk("tbl_x31", regs[31], 64'd0);

        // Steady stream of four writes: ready never drops, all land in order
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(5'(i), 64'h1000 + 64'(i));
        idle(2);
        for (int i = 0; i < 4; i++) chk("stream_reg", regs[i], 64'h1000 + 64'(i));

        // Same address back-to-back: first value, then second, last wins
        send(5'd5, 64'h11);
        send(5'd5, 64'h22);
        @(negedge clk);
        chk("same_first", regs[5], 64'h11);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("same_second", regs[5], 64'h22);
        idle(1);

        // Reset arriving while a write is still pending discards it
        send(5'd7, 64'h55);
        do_reset(1);
        @(negedge clk);
        chk("midrst_reg7", regs[7], 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(wr_ready), 64'd1);
        chk("midrst_reg5", regs[5], 64'd0);
        idle(2);

        // Exhaustive sweep of every address, back-to-back
        for (int i = 0; i < 32; i++) send(5'(i), 64'(i + 1));
        idle(2);
        for (int i = 0; i < 32; i++) begin
            chk("sweep_reg", regs[i], (i < 31) ? 64'(i + 1) : 64'd0);
        end
        chk("sweep_busy", 64'(busy), 64'd0);

        idle(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
